// File: rtl/sine_arb_pkg.sv
// -----------------------------------------------------------------------------
// sine_arb_pkg
// Shared definitions for the sine lookup arbiter:
//   - arb_state_t  : lookup sequencer states (IDLE, WAIT, CAPT)
//   - DEF_ROM_DEPTH: default sine_table entries per quadrant
//   - DEF_ROM_WIDTH: default sine_table ROM word width
//   - QUARTER_TURN : angle offset that turns a sine lookup into a cosine lookup
//   - rr_index()   : modular index helper used by the round-robin search
// -----------------------------------------------------------------------------
package sine_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2
    } arb_state_t;

    localparam int DEF_ROM_DEPTH = 64;
    localparam int DEF_ROM_WIDTH = 8;

    // One quadrant of the table is 90 degrees: cos(a) == sin(a + 90deg).
    localparam int QUARTER_TURN  = DEF_ROM_DEPTH;

    // (base + offset) mod n for small non-negative operands.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/sine_lookup_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin one-hot grant generator with its own priority pointer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : grant allowed this cycle (arbiter owner is idle)
//   req        : request vector
//   grant      : one-hot grant, first set req searching upward from rr_ptr
//   grant_idx  : binary index of the granted requester
//   accept     : a grant is being issued this cycle
// The pointer moves to one past the granted requester on every accept.
// -----------------------------------------------------------------------------
module rr_arbiter
    import sine_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTRW    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTRW-1:0]    grant_idx,
    output logic               accept
);

    logic [PTRW-1:0]    rr_ptr_r;
    logic [NUM_REQ-1:0] grant_s;
    logic [PTRW-1:0]    grant_idx_s;
    logic               found_s;
    logic [PTRW-1:0]    idx_s;

    // First requester at or above rr_ptr (with wrap) wins; nothing while in reset.
    always_comb begin
        grant_s     = {NUM_REQ{1'b0}};
        grant_idx_s = {PTRW{1'b0}};
        found_s     = 1'b0;
        idx_s       = {PTRW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = PTRW'(rr_index(int'(rr_ptr_r), k, NUM_REQ));
            if (!found_s && req[idx_s] && enable && !rst) begin
                found_s        = 1'b1;
                grant_s[idx_s] = 1'b1;
                grant_idx_s    = idx_s;
            end else begin
                // a higher-priority requester already won, or this one is idle
            end
        end
    end

    // Priority pointer: start the next search just past the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= {PTRW{1'b0}};
        end else if (found_s) begin
            rr_ptr_r <= PTRW'(rr_index(int'(grant_idx_s), 1, NUM_REQ));
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign grant     = grant_s;
    assign grant_idx = grant_idx_s;
    assign accept    = found_s;

endmodule

// File: rtl/sine_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// sine_lookup_arbiter
// Shares one sine_table lookup port among NUM_REQ requesters.
// The table mixes live-address quadrant logic with a registered ROM, so the
// address is held stable for the full LATENCY before the result is captured.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-requester request pending
//   req_angle  : per-requester angle (full circle = 2^ADDRW)
//   req_cos    : per-requester 1 = cosine, 0 = sine
//   req_ready  : one-hot combinational grant (only while IDLE)
//   rsp_valid  : one-cycle result strobe to the requester that owns the lookup
//   rsp_data   : signed result, held until the next response
//   tbl_id     : address to sine_table id (held between accepts)
//   tbl_data   : sine_table data
//   busy       : a lookup is in flight (WAIT or CAPT)
// -----------------------------------------------------------------------------
module sine_lookup_arbiter
    import sine_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ROM_DEPTH = DEF_ROM_DEPTH,
    parameter int ROM_WIDTH = DEF_ROM_WIDTH,
    parameter int ADDRW     = $clog2(4 * ROM_DEPTH),
    parameter int LATENCY   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][ADDRW-1:0] req_angle,
    input  logic [NUM_REQ-1:0]            req_cos,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic signed [2*ROM_WIDTH-1:0] rsp_data,
    output logic [ADDRW-1:0]              tbl_id,
    input  logic signed [2*ROM_WIDTH-1:0] tbl_data,
    output logic                          busy
);

    localparam int PTRW = $clog2(NUM_REQ);
    localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Cosine is a quarter turn ahead; a quadrant is ROM_DEPTH table steps.
    localparam logic [ADDRW-1:0] COS_OFFSET = ADDRW'(ROM_DEPTH);

    arb_state_t                   state_r;
    arb_state_t                   state_next_s;
    logic [CNTW-1:0]              count_r;
    logic [PTRW-1:0]              owner_r;
    logic [ADDRW-1:0]             tbl_id_r;
    logic signed [2*ROM_WIDTH-1:0] rsp_data_r;
    logic [NUM_REQ-1:0]           rsp_valid_r;
    logic                         busy_r;

    logic                         enable_s;
    logic [NUM_REQ-1:0]           grant_s;
    logic [PTRW-1:0]              grant_idx_s;
    logic                         accept_s;
    logic [ADDRW-1:0]             id_next_s;

    assign enable_s = (state_r == IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTRW    (PTRW)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable_s),
        .req       (req_valid),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .accept    (accept_s)
    );

    // Table address for the winner; the ADDRW-bit add wraps past a full turn.
    always_comb begin
        id_next_s = req_angle[grant_idx_s];
        if (req_cos[grant_idx_s]) begin
            id_next_s = req_angle[grant_idx_s] + COS_OFFSET;
        end else begin
            id_next_s = req_angle[grant_idx_s];
        end
    end

    // Sequencer next state: accept -> hold address LATENCY cycles -> capture.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (count_r == CNTW'(LATENCY - 1)) begin
                    state_next_s = CAPT;
                end else begin
                    state_next_s = WAIT;
                end
            end
            CAPT:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, held address, latency counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= {CNTW{1'b0}};
            owner_r     <= {PTRW{1'b0}};
            tbl_id_r    <= {ADDRW{1'b0}};
            rsp_data_r  <= {(2*ROM_WIDTH){1'b0}};
            rsp_valid_r <= {NUM_REQ{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            busy_r      <= (state_next_s != IDLE);
            rsp_valid_r <= {NUM_REQ{1'b0}};
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        tbl_id_r <= id_next_s;
                        owner_r  <= grant_idx_s;
                        count_r  <= {CNTW{1'b0}};
                    end else begin
                        tbl_id_r <= tbl_id_r;
                    end
                end
                WAIT: begin
                    count_r <= count_r + CNTW'(1);
                end
                CAPT: begin
                    // Address has been stable for LATENCY cycles: data is valid now.
                    rsp_data_r  <= tbl_data;
                    rsp_valid_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r;
                end
                default: begin
                    count_r <= {CNTW{1'b0}};
                end
            endcase
        end
    end

    assign req_ready = grant_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign tbl_id    = tbl_id_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_sine_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sine_lookup_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level model
// (grant pointer, cycles since accept, held address, last result) predicts
// every output each cycle; a behavioural sine table with programmable latency
// stands in for sine_table.
// -----------------------------------------------------------------------------
module tb_sine_lookup_arbiter;

    localparam int NREQ  = 4;
    localparam int DEPTH = 64;
    localparam int RW    = 8;
    localparam int AW    = 8;
    localparam int LAT   = 2;

    logic                       clk;
    logic                       rst;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0][AW-1:0]    req_angle;
    logic [NREQ-1:0]            req_cos;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            rsp_valid;
    logic signed [2*RW-1:0]     rsp_data;
    logic [AW-1:0]              tbl_id;
    logic signed [2*RW-1:0]     tbl_data;
    logic                       busy;

    int checks   = 0;
    int failures = 0;

    // model state
    int          m_rr;
    int          m_since;
    int          m_owner;
    logic [7:0]  m_id;
    logic [15:0] m_rsp;
    logic [NREQ-1:0] last_grant;
    logic [NREQ-1:0] obs_ready;
    int          grant_q[$];

    sine_lookup_arbiter #(
        .NUM_REQ   (NREQ),
        .ROM_DEPTH (DEPTH),
        .ROM_WIDTH (RW),
        .ADDRW     (AW),
        .LATENCY   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_angle (req_angle),
        .req_cos   (req_cos),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .tbl_id    (tbl_id),
        .tbl_data  (tbl_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8.8 sine of id/256 of a full turn, rounded to nearest.
    function automatic logic [15:0] sine_ref(input int id);
        real v;
        int  iv;
        v = 256.0 * $sin(2.0 * 3.14159265358979 * real'(id) / 256.0);
        if (v >= 0.0) iv = $rtoi(v + 0.5);
        else          iv = -$rtoi(0.5 - v);
        return 16'(iv);
    endfunction

    // behavioural table: data follows id after LAT clock edges
    logic signed [15:0] tbl_pipe [LAT];
    always_ff @(posedge clk) begin
        tbl_pipe[0] <= sine_ref(int'(tbl_id));
        for (int k = 1; k < LAT; k++) tbl_pipe[k] <= tbl_pipe[k-1];
    end
    assign tbl_data = tbl_pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr    = 0;
        m_since = 100;
        m_owner = 0;
        m_id    = 8'd0;
        m_rsp   = 16'd0;
    endtask

    // One clock cycle: predict and compare at the falling edge, then advance model.
    task automatic cycle();
        logic [NREQ-1:0] g;
        int gi;
        logic idle;
        @(negedge clk);
        idle = (m_since >= LAT + 2);
        g  = '0;
        gi = -1;
        if (idle && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_rr + k) % NREQ;
                if (gi < 0 && req_valid[j]) begin
                    gi    = j;
                    g[j]  = 1'b1;
                end
            end
        end
        obs_ready = req_ready;
        chk("req_ready", {28'd0, req_ready}, {28'd0, g});
        chk("busy", {31'd0, busy}, {31'd0, 1'((m_since >= 1) && (m_since <= LAT + 1))});
        chk("tbl_id", {24'd0, tbl_id}, {24'd0, m_id});
        chk("rsp_valid", {28'd0, rsp_valid}, (m_since == LAT + 2) ? (32'd1 << m_owner) : 32'd0);
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, m_rsp});
        last_grant = g;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (gi >= 0) begin
                m_id    = 8'((int'(req_angle[gi]) + (req_cos[gi] ? DEPTH : 0)) % 256);
                m_owner = gi;
                m_rr    = (gi + 1) % NREQ;
                m_since = 1;
                grant_q.push_back(gi);
            end else if (m_since < 100) begin
                m_since++;
            end
            if (m_since == LAT + 2) m_rsp = sine_ref(int'(m_id));
        end
    endtask

    // Async reset applied mid-cycle: outputs must clear at once.
    task automatic async_reset_now();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tbl_id", {24'd0, tbl_id}, 32'd0);
        chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        cycle();
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic rand_drive();
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && last_grant[i]) begin
                req_valid[i] = 1'($urandom_range(0, 1));
                req_angle[i] = 8'($urandom_range(0, 255));
                req_cos[i]   = 1'($urandom_range(0, 1));
            end else if (req_valid[i]) begin
                if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                req_valid[i] = 1'b1;
                req_angle[i] = 8'($urandom_range(0, 255));
                req_cos[i]   = 1'($urandom_range(0, 1));
            end
        end
    endtask

    initial begin
        int cnt;
        rst       = 1'b1;
        req_valid = '0;
        req_angle = '0;
        req_cos   = '0;
        last_grant = '0;
        model_reset();
        #1;
        idle_cycles(2);
        rst = 1'b0;

        // 1: single sine at 90 degrees
        req_valid[0] = 1'b1; req_angle[0] = 8'd64; req_cos[0] = 1'b0;
        cycle();
        chk("t1_ready", {28'd0, obs_ready}, 32'h1);
        req_valid[0] = 1'b0;
        idle_cycles(4);
        chk("t1_data", {16'd0, rsp_data}, 32'h0100);

        // 2: cosine address wraps; sine at 270 degrees is -1.0
        req_valid[1] = 1'b1; req_angle[1] = 8'd200; req_cos[1] = 1'b1;
        cycle();
        req_valid[1] = 1'b0;
        chk("t2_cos_wrap", {24'd0, tbl_id}, 32'd8);
        idle_cycles(4);
        req_valid[1] = 1'b1; req_angle[1] = 8'd192; req_cos[1] = 1'b0;
        cycle();
        req_valid[1] = 1'b0;
        idle_cycles(4);
        chk("t2_minus_one", {16'd0, rsp_data}, 32'hFF00);

        // 3: contention right after reset, then two held requesters alternate
        async_reset_now();
        for (int i = 0; i < NREQ; i++) begin
            req_angle[i] = 8'($urandom_range(0, 255));
            req_cos[i]   = 1'($urandom_range(0, 1));
        end
        req_valid = 4'b1111;
        grant_q.delete();
        for (int k = 0; k < 16; k++) begin
            cycle();
            req_valid = req_valid & ~last_grant;
        end
        chk("t3_order_n", 32'(grant_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_q.size(); i++) chk("t3_order", 32'(grant_q[i]), 32'(i));
        grant_q.delete();
        req_valid = 4'b0101;
        idle_cycles(16);
        chk("t3_alt_n", 32'(grant_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_q.size(); i++) chk("t3_alt", 32'(grant_q[i]), 32'((i % 2) * 2));
        req_valid = '0;
        idle_cycles(4);

        // 4: back-to-back on one requester
        grant_q.delete();
        req_valid[3] = 1'b1; req_angle[3] = 8'd32; req_cos[3] = 1'b0;
        idle_cycles(12);
        chk("t4_grants", 32'(grant_q.size()), 32'd3);
        req_valid = '0;
        idle_cycles(4);

        // 5: reset in WAIT discards the lookup; pointer back at 0
        req_valid[1] = 1'b1; req_angle[1] = 8'd10;
        cycle();
        req_valid[1] = 1'b0;
        cycle();
        async_reset_now();
        req_valid = 4'b0101;
        cycle();
        chk("t5_first", {28'd0, obs_ready}, 32'h1);
        req_valid = '0;
        idle_cycles(5);

        // 6: requester 1 withdraws while busy
        grant_q.delete();
        req_valid[0] = 1'b1;
        cycle();
        req_valid[0] = 1'b0;
        cycle();
        req_valid[1] = 1'b1;
        idle_cycles(2);
        req_valid[1] = 1'b0;
        idle_cycles(4);
        cnt = 0;
        foreach (grant_q[i]) if (grant_q[i] == 1) cnt++;
        chk("t6_no_grant1", 32'(cnt), 32'd0);

        // randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 79) == 0) async_reset_now();
            else cycle();
            rand_drive();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
